// File: rtl/write_resp_channel_ctrl_pkg.sv
// Shared types and constants for the write-response (B) routing block.
package write_resp_pkg;

  localparam int MASTERS_NUM = 2;
  localparam int ID_W        = $clog2(MASTERS_NUM);

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef logic [1:0]      bresp_t;
  typedef logic [ID_W-1:0] master_id_t;

  typedef enum logic {
    SLV_M00 = 1'b0,
    SLV_M01 = 1'b1
  } slave_sel_e;

endpackage

// File: rtl/write_resp_channel_ctrl_if.sv
// B-channel bundle between the two slave ports (M0x) and the two master ports (S0x).
interface write_resp_channel_ctrl_if;
  import write_resp_pkg::*;

  bresp_t M00_AXI_bresp;
  bresp_t M01_AXI_bresp;
  logic   M00_AXI_bvalid;
  logic   M01_AXI_bvalid;
  logic   M00_AXI_bready;
  logic   M01_AXI_bready;

  bresp_t S00_AXI_bresp;
  bresp_t S01_AXI_bresp;
  logic   S00_AXI_bvalid;
  logic   S01_AXI_bvalid;
  logic   S00_AXI_bready;
  logic   S01_AXI_bready;

  // master: the routing controller; slave: the surrounding slaves and masters.
  modport master (
    input  M00_AXI_bresp, M01_AXI_bresp, M00_AXI_bvalid, M01_AXI_bvalid,
    output M00_AXI_bready, M01_AXI_bready,
    output S00_AXI_bresp, S01_AXI_bresp, S00_AXI_bvalid, S01_AXI_bvalid,
    input  S00_AXI_bready, S01_AXI_bready
  );

  modport slave (
    output M00_AXI_bresp, M01_AXI_bresp, M00_AXI_bvalid, M01_AXI_bvalid,
    input  M00_AXI_bready, M01_AXI_bready,
    input  S00_AXI_bresp, S01_AXI_bresp, S00_AXI_bvalid, S01_AXI_bvalid,
    output S00_AXI_bready, S01_AXI_bready
  );
endinterface

// File: rtl/write_resp_channel_ctrl_resp_id_fifo.sv
// Per-slave ordering FIFO of issuing master IDs; push while full is accepted only
// when a pop frees the slot in the same cycle.
module resp_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/write_resp_channel_ctrl.sv
// Routes B responses from slaves M00/M01 back to the issuing master S00/S01 in AW order.
// Optional macro WRITE_RESP_ORPHAN_DROP_EN: accept and drop responses that have no pending AW.
module write_resp_channel_ctrl
  import write_resp_pkg::*;
#(
  parameter int Masters_Num     = 2,
  parameter int Num_Of_Slaves   = 2,
  parameter int Slaves_ID_Size  = $clog2(Masters_Num),
  parameter int Outstanding_Max = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      AW_Push,
  input  logic [Slaves_ID_Size-1:0] AW_Master_ID,
  input  logic                      AW_Slave_Sel,
  output logic [Num_Of_Slaves-1:0]  Queue_Is_Full,
  output logic                      Orphan_Resp_Err,
  write_resp_channel_ctrl_if.master bus
);

  logic                      w_bvalid    [Num_Of_Slaves];
  bresp_t                    w_bresp     [Num_Of_Slaves];
  logic [Slaves_ID_Size-1:0] w_head      [Num_Of_Slaves];
  logic                      w_empty     [Num_Of_Slaves];
  logic                      w_full      [Num_Of_Slaves];
  logic                      w_push      [Num_Of_Slaves];
  logic                      w_pop       [Num_Of_Slaves];
  logic                      w_bready    [Num_Of_Slaves];

  logic                      w_sready    [Masters_Num];
  logic [Num_Of_Slaves-1:0]  w_cand      [Masters_Num];
  logic                      w_free      [Masters_Num];
  logic                      w_grant_vld [Masters_Num];
  slave_sel_e                w_grant_sel [Masters_Num];
  slave_sel_e                r_rr        [Masters_Num];
  logic                      r_valid     [Masters_Num];
  bresp_t                    r_bresp     [Masters_Num];

  assign w_bvalid[0] = bus.M00_AXI_bvalid;
  assign w_bvalid[1] = bus.M01_AXI_bvalid;
  assign w_bresp[0]  = bus.M00_AXI_bresp;
  assign w_bresp[1]  = bus.M01_AXI_bresp;
  assign w_sready[0] = bus.S00_AXI_bready;
  assign w_sready[1] = bus.S01_AXI_bready;

  for (genvar s = 0; s < Num_Of_Slaves; s++) begin : g_fifo
    assign w_push[s]        = AW_Push && (AW_Slave_Sel == 1'(s));
    assign Queue_Is_Full[s] = w_full[s];

    resp_id_fifo #(
      .WIDTH (Slaves_ID_Size),
      .DEPTH (Outstanding_Max)
    ) u_fifo (
      .i_clk   (ACLK),
      .i_rst_n (ARESETN),
      .i_push  (w_push[s]),
      .i_data  (AW_Master_ID),
      .i_pop   (w_pop[s]),
      .o_head  (w_head[s]),
      .o_full  (w_full[s]),
      .o_empty (w_empty[s])
    );
  end

  // A slave's head ID names exactly one master, so the per-master grants never collide on a slave.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    for (int m = 0; m < Masters_Num; m++) begin
      w_free[m]      = !r_valid[m] || w_sready[m];
      w_grant_vld[m] = 1'b0;
      w_grant_sel[m] = SLV_M00;
      for (int s = 0; s < Num_Of_Slaves; s++) begin
        w_cand[m][s] = w_bvalid[s] && !w_empty[s] && (w_head[s] == Slaves_ID_Size'(m));
      end
      if (w_free[m]) begin
        if (&w_cand[m]) begin
          w_grant_vld[m] = 1'b1;
          w_grant_sel[m] = r_rr[m];
        end else if (w_cand[m][0]) begin
          w_grant_vld[m] = 1'b1;
          w_grant_sel[m] = SLV_M00;
        end else if (w_cand[m][1]) begin
          w_grant_vld[m] = 1'b1;
          w_grant_sel[m] = SLV_M01;
        end
      end
    end
    for (int s = 0; s < Num_Of_Slaves; s++) begin
      w_pop[s] = 1'b0;
      for (int m = 0; m < Masters_Num; m++) begin
        if (w_grant_vld[m] && (w_grant_sel[m] == slave_sel_e'(s))) w_pop[s] = 1'b1;
      end
    end
  end

`ifdef WRITE_RESP_ORPHAN_DROP_EN
  logic w_orphan [Num_Of_Slaves];
  logic r_orphan;

  always_comb begin
    for (int s = 0; s < Num_Of_Slaves; s++) begin
      w_orphan[s] = w_bvalid[s] && w_empty[s];
      w_bready[s] = w_pop[s] || w_orphan[s];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_orphan <= 1'b0;
    end else if (w_orphan[0] || w_orphan[1]) begin
      r_orphan <= 1'b1;
    end
  end

  assign Orphan_Resp_Err = r_orphan;
`else
  always_comb begin
    for (int s = 0; s < Num_Of_Slaves; s++) begin
      w_bready[s] = w_pop[s];
    end
  end

  assign Orphan_Resp_Err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int m = 0; m < Masters_Num; m++) begin
        r_valid[m] <= 1'b0;
        r_bresp[m] <= BRESP_OKAY;
        r_rr[m]    <= SLV_M00;
      end
    end else begin
      for (int m = 0; m < Masters_Num; m++) begin
        if (w_grant_vld[m]) begin
          r_valid[m] <= 1'b1;
          r_bresp[m] <= w_bresp[w_grant_sel[m]];
        end else if (w_sready[m]) begin
          r_valid[m] <= 1'b0;
        end
        // Pointer only advances when both slaves competed for this master.
        if (w_grant_vld[m] && (&w_cand[m])) begin
          r_rr[m] <= (w_grant_sel[m] == SLV_M00) ? SLV_M01 : SLV_M00;
        end
      end
    end
  end

  assign bus.M00_AXI_bready = w_bready[0];
  assign bus.M01_AXI_bready = w_bready[1];
  assign bus.S00_AXI_bvalid = r_valid[0];
  assign bus.S01_AXI_bvalid = r_valid[1];
  assign bus.S00_AXI_bresp  = r_bresp[0];
  assign bus.S01_AXI_bresp  = r_bresp[1];

endmodule

// File: tb/tb_write_resp_channel_ctrl.sv
// Self-checking bench for write_resp_channel_ctrl: directed scenarios then random traffic,
// compared every cycle against a queue-based model of response routing.
module tb_write_resp_channel_ctrl;
  import write_resp_pkg::*;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       AW_Push;
  master_id_t AW_Master_ID;
  logic       AW_Slave_Sel;
  logic [1:0] Queue_Is_Full;
  logic       Orphan_Resp_Err;

  write_resp_channel_ctrl_if bif ();

  write_resp_channel_ctrl dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .AW_Push         (AW_Push),
    .AW_Master_ID    (AW_Master_ID),
    .AW_Slave_Sel    (AW_Slave_Sel),
    .Queue_Is_Full   (Queue_Is_Full),
    .Orphan_Resp_Err (Orphan_Resp_Err),
    .bus             (bif)
  );

  always #5 ACLK = ~ACLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: ordered ID queues per slave, expected master outputs, preferred slave per master.
  int     q0[$];
  int     q1[$];
  bit     ev[2];
  bresp_t er[2];
  int     rr[2];
  bit     eorph;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qhead(input int s);
    return (s == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int s);
    if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qpush(input int s, input int v);
    if (s == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      ev[m] = 1'b0;
      er[m] = BRESP_OKAY;
      rr[m] = 0;
    end
    eorph = 1'b0;
  endtask

  task automatic set_aw(input bit push, input int id, input int sel);
    AW_Push      = push;
    AW_Master_ID = master_id_t'(id);
    AW_Slave_Sel = sel[0];
  endtask

  task automatic set_b(input bit v0, input bresp_t r0, input bit v1, input bresp_t r1);
    bif.M00_AXI_bvalid = v0;
    bif.M00_AXI_bresp  = r0;
    bif.M01_AXI_bvalid = v1;
    bif.M01_AXI_bresp  = r1;
  endtask

  task automatic set_rdy(input bit r0, input bit r1);
    bif.S00_AXI_bready = r0;
    bif.S01_AXI_bready = r1;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    bit         bv[2];
    bresp_t     br[2];
    bit         sb[2];
    bit         was_empty[2];
    bit         rdy[2];
    bit         c0, c1;
    int         g[2];
    bit         push;
    int         pid, psel;
    logic [1:0] efull;

    bv[0] = bif.M00_AXI_bvalid;  bv[1] = bif.M01_AXI_bvalid;
    br[0] = bif.M00_AXI_bresp;   br[1] = bif.M01_AXI_bresp;
    sb[0] = bif.S00_AXI_bready;  sb[1] = bif.S01_AXI_bready;
    push  = AW_Push;  pid = int'(AW_Master_ID);  psel = int'(AW_Slave_Sel);

    for (int s = 0; s < 2; s++) begin
      was_empty[s] = (qsize(s) == 0);
      rdy[s]       = 1'b0;
    end
    for (int m = 0; m < 2; m++) begin
      g[m] = -1;
      c0 = bv[0] && !was_empty[0] && (qhead(0) == m);
      c1 = bv[1] && !was_empty[1] && (qhead(1) == m);
      if (!ev[m] || sb[m]) begin
        if (c0 && c1) begin
          g[m]  = rr[m];
          rr[m] = 1 - g[m];
        end else if (c0) g[m] = 0;
        else if (c1)     g[m] = 1;
      end
      if (g[m] >= 0) rdy[g[m]] = 1'b1;
    end
`ifdef WRITE_RESP_ORPHAN_DROP_EN
    for (int s = 0; s < 2; s++) if (bv[s] && was_empty[s]) rdy[s] = 1'b1;
`endif
    efull = {qsize(1) == 4, qsize(0) == 4};

    #1;
    check("M00_bready", bif.M00_AXI_bready, rdy[0]);
    check("M01_bready", bif.M01_AXI_bready, rdy[1]);
    check("Queue_Is_Full", Queue_Is_Full, efull);

    @(posedge ACLK);
    for (int m = 0; m < 2; m++) if (g[m] >= 0) qpop(g[m]);
    if (push && qsize(psel) < 4) qpush(psel, pid);
    for (int m = 0; m < 2; m++) begin
      if (g[m] >= 0) begin
        ev[m] = 1'b1;
        er[m] = br[g[m]];
      end else if (sb[m]) begin
        ev[m] = 1'b0;
      end
    end
`ifdef WRITE_RESP_ORPHAN_DROP_EN
    for (int s = 0; s < 2; s++) if (bv[s] && was_empty[s]) eorph = 1'b1;
`endif

    @(negedge ACLK);
    check("S00_bvalid", bif.S00_AXI_bvalid, ev[0]);
    check("S00_bresp", bif.S00_AXI_bresp, er[0]);
    check("S01_bvalid", bif.S01_AXI_bvalid, ev[1]);
    check("S01_bresp", bif.S01_AXI_bresp, er[1]);
    check("Orphan_Resp_Err", Orphan_Resp_Err, eorph);
  endtask

  initial begin
    ARESETN = 1'b0;
    set_aw(0, 0, 0);
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY);
    set_rdy(0, 0);
    model_reset();
    repeat (2) @(negedge ACLK);

    // Reset state
    check("rst_S00_bvalid", bif.S00_AXI_bvalid, 1'b0);
    check("rst_S01_bvalid", bif.S01_AXI_bvalid, 1'b0);
    check("rst_S00_bresp", bif.S00_AXI_bresp, BRESP_OKAY);
    check("rst_S01_bresp", bif.S01_AXI_bresp, BRESP_OKAY);
    check("rst_full", Queue_Is_Full, 2'b00);
    check("rst_M00_bready", bif.M00_AXI_bready, 1'b0);
    check("rst_M01_bready", bif.M01_AXI_bready, 1'b0);
    check("rst_orphan", Orphan_Resp_Err, 1'b0);
    ARESETN = 1'b1;

    // Single response: ID1 via slave 0 lands on S01 one cycle after the slave handshake
    set_aw(1, 1, 0); cycle();
    set_aw(0, 0, 0);
    set_b(1, BRESP_OKAY, 0, BRESP_OKAY); set_rdy(1, 1); cycle();
    check("t1_S01_bvalid", bif.S01_AXI_bvalid, 1'b1);
    check("t1_S00_bvalid", bif.S00_AXI_bvalid, 1'b0);
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY); cycle();

    // Contention for S00: M00 first, M01 next cycle
    set_aw(1, 0, 0); cycle();
    set_aw(1, 0, 1); cycle();
    set_aw(0, 0, 0);
    set_b(1, BRESP_EXOKAY, 1, BRESP_SLVERR); cycle();
    check("t2_first_resp", bif.S00_AXI_bresp, BRESP_EXOKAY);
    set_b(0, BRESP_OKAY, 1, BRESP_SLVERR); cycle();
    check("t2_second_resp", bif.S00_AXI_bresp, BRESP_SLVERR);
    check("t2_second_valid", bif.S00_AXI_bvalid, 1'b1);
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY); cycle();

    // Backpressure on S01: pending response holds, next slave response stalls
    set_aw(1, 1, 0); cycle();
    cycle();
    set_aw(0, 0, 0);
    set_rdy(1, 0);
    set_b(1, BRESP_DECERR, 0, BRESP_OKAY); cycle();
    set_b(1, BRESP_OKAY, 0, BRESP_OKAY);
    repeat (3) cycle();
    check("t3_hold_bresp", bif.S01_AXI_bresp, BRESP_DECERR);
    set_rdy(1, 1); cycle();
    check("t3_next_bresp", bif.S01_AXI_bresp, BRESP_OKAY);
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY); cycle();

    // Fill slave 1, overflow push, push+pop while full
    for (int i = 0; i < 4; i++) begin
      set_aw(1, int'($urandom_range(0, 1)), 1); cycle();
    end
    check("t4_full", Queue_Is_Full, 2'b10);
    set_aw(1, 0, 1); cycle();
    set_aw(1, 1, 1); set_b(0, BRESP_OKAY, 1, BRESP_SLVERR); cycle();
    check("t4_full_after_pushpop", Queue_Is_Full, 2'b10);
    set_aw(0, 0, 0);
    repeat (4) cycle();
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY); cycle();

    // Orphan response on empty slave 1
    set_b(0, BRESP_OKAY, 1, BRESP_SLVERR);
    repeat (3) cycle();
`ifdef WRITE_RESP_ORPHAN_DROP_EN
    check("t5_orphan_flag", Orphan_Resp_Err, 1'b1);
`else
    check("t5_stall_bready", bif.M01_AXI_bready, 1'b0);
`endif
    check("t5_no_forward", bif.S00_AXI_bvalid, 1'b0);
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY); cycle();

    // Reset mid-burst: S00 holding a response, slave 0 FIFO holding 3
    set_rdy(0, 0);
    for (int i = 0; i < 4; i++) begin
      set_aw(1, 0, 0); cycle();
    end
    set_aw(0, 0, 0);
    set_b(1, BRESP_SLVERR, 0, BRESP_OKAY); cycle();
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY);
    check("t6_pre_S00_bvalid", bif.S00_AXI_bvalid, 1'b1);
    ARESETN = 1'b0;
    #1;
    check("t6_S00_bvalid", bif.S00_AXI_bvalid, 1'b0);
    check("t6_S00_bresp", bif.S00_AXI_bresp, BRESP_OKAY);
    check("t6_full", Queue_Is_Full, 2'b00);
    check("t6_orphan", Orphan_Resp_Err, 1'b0);
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    set_rdy(1, 1);
    set_b(1, BRESP_OKAY, 0, BRESP_OKAY); cycle();
    set_b(0, BRESP_OKAY, 0, BRESP_OKAY); cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_aw(($urandom_range(0, 99) < 45), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      set_b(($urandom_range(0, 99) < 60), bresp_t'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 60), bresp_t'($urandom_range(0, 3)));
      set_rdy(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
